bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift per cycle, fixed
// BIN_W+1 cycle latency, saturating to all nines when the value needs more than NDIG digits.
module bin2bcd_seq #(
  parameter int BIN_W = 27,
  parameter int NDIG  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BIN_W-1:0]  bin,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] bcd,
  output logic              ovf
);
  localparam int SW = 4*NDIG + 4;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, FIN = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  sh_q, sh_d;
  logic [SW-1:0]     scr_q, scr_d, adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic [4*NDIG-1:0] bcd_q, bcd_d;

  for (genvar g = 0; g < NDIG + 1; g++) begin : g_adj
    assign adj[4*g +: 4] = (scr_q[4*g +: 4] >= 4'd5) ? scr_q[4*g +: 4] + 4'd3
                                                      : scr_q[4*g +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          sh_d    = bin;
          scr_d   = '0;
          cnt_d   = CW'(BIN_W);
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        // Top scratch bit is sticky: anything that ever reached the guard
        // nibble stays visible so an overflow cannot shift out unnoticed.
        scr_d = {adj[SW-1] | adj[SW-2] | (|scr_q[SW-1:SW-4]), adj[SW-3:0], sh_q[BIN_W-1]};
        sh_d  = {sh_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIN;
      end
      FIN: begin
        if (|scr_q[SW-1:SW-4]) begin
          ovf_d = 1'b1;
          bcd_d = {NDIG{4'h9}};
        end else begin
          ovf_d = 1'b0;
          bcd_d = scr_q[4*NDIG-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
endmodule
